// File: rtl/vend_pkg.sv
// vend_pkg: shared types and defaults for the vending balance controller.
// Audit width is used only when BALANCE_AUDIT_EN is defined.
package vend_pkg;

  localparam int DEF_MONEY_W     = 4;
  localparam int DEF_MAX_BALANCE = 15;
  localparam int DEF_RED_HOLD    = 4;
  localparam int AUDIT_W         = 8;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_C,
    SERVE_O,
    ERR
  } state_t;

  function automatic logic [AUDIT_W-1:0] sat_add(
    input logic [AUDIT_W-1:0] a,
    input logic [AUDIT_W-1:0] b
  );
    logic [AUDIT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[AUDIT_W] ? '1 : s[AUDIT_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter, req[0]=customer, req[1]=owner.
// Grant is combinational; last-grant pointer updates on each enabled grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_own;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_own ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Reset value says "owner went last" so the customer wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_own <= 1'b1;
    end else if (en && (|req)) begin
      last_own <= gnt[1];
    end
  end

endmodule

// File: rtl/vend_balance_ctrl.sv
// vend_balance_ctrl: balance register, customer/owner arbitration, payout, red light.
// Optional: BALANCE_AUDIT_EN adds the saturating audit_total output.
module vend_balance_ctrl
  import vend_pkg::*;
#(
  parameter int MONEY_W     = DEF_MONEY_W,
  parameter int MAX_BALANCE = DEF_MAX_BALANCE,
  parameter int RED_HOLD    = DEF_RED_HOLD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cust_req,
  input  logic [MONEY_W-1:0] cust_amt,
  output logic               cust_gnt,
  output logic               cust_nack,
  input  logic               own_req,
  output logic               own_gnt,
  output logic [MONEY_W-1:0] machine_money,
  output logic               wd_valid,
  output logic [MONEY_W-1:0] wd_amt,
  output logic               red_light
`ifdef BALANCE_AUDIT_EN
  ,
  output logic [AUDIT_W-1:0] audit_total
`endif
);

  localparam int CNT_W = (RED_HOLD > 1) ? $clog2(RED_HOLD) : 1;

  state_t             state;
  logic [1:0]         arb_req;
  logic [1:0]         arb_gnt;
  logic               arb_en;
  logic [MONEY_W:0]   sum;
  logic               fits;
  logic [MONEY_W-1:0] pend_bal;
  logic [CNT_W-1:0]   hold_cnt;

  assign arb_req = {own_req, cust_req};
  assign arb_en  = (state == IDLE);

  // One extra bit so an overflowing deposit compares as too large.
  assign sum  = {1'b0, machine_money} + {1'b0, cust_amt};
  assign fits = (sum <= (MONEY_W+1)'(MAX_BALANCE));

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   (arb_req),
    .gnt   (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      machine_money <= '0;
      pend_bal      <= '0;
      hold_cnt      <= '0;
      cust_gnt      <= 1'b0;
      cust_nack     <= 1'b0;
      own_gnt       <= 1'b0;
      wd_valid      <= 1'b0;
      wd_amt        <= '0;
      red_light     <= 1'b0;
    end else begin
      cust_gnt  <= 1'b0;
      cust_nack <= 1'b0;
      own_gnt   <= 1'b0;
      wd_valid  <= 1'b0;
      wd_amt    <= '0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            arb_gnt[0]: begin
              state     <= SERVE_C;
              cust_gnt  <= 1'b1;
              cust_nack <= !fits;
              pend_bal  <= sum[MONEY_W-1:0];
            end
            arb_gnt[1]: begin
              state    <= SERVE_O;
              own_gnt  <= 1'b1;
              wd_valid <= |machine_money;
              wd_amt   <= machine_money;
            end
            default: ;
          endcase
        end
        SERVE_C: begin
          if (!cust_nack) machine_money <= pend_bal;
          state <= IDLE;
        end
        SERVE_O: begin
          if (wd_valid) begin
            machine_money <= '0;
            state         <= IDLE;
          end else begin
            state     <= ERR;
            red_light <= 1'b1;
            hold_cnt  <= CNT_W'(RED_HOLD - 1);
          end
        end
        ERR: begin
          if (hold_cnt == '0) begin
            red_light <= 1'b0;
            state     <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BALANCE_AUDIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audit_total <= '0;
    end else if (state == SERVE_O && wd_valid) begin
      audit_total <= sat_add(audit_total, AUDIT_W'(wd_amt));
    end
  end
`endif

endmodule
